regfile_2r1w_sb: RTL and testbench

- Parametrised dual-read, single-write register file with registered reads and same-cycle write bypass.
- Adds byte-masked writes, an optional hardwired zero register, and a per-register pending scoreboard for producer/consumer hazard tracking.
- Adds a sequential clear engine.
- Sits between decode (read addresses, reservations) and writeback (write port) in the processor datapath.

---
 rtl/regfile_2r1w_sb.sv | 215 +++++++++++++++++++++
 tb/tb_regfile_2r1w_sb.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_2r1w_sb.sv
// regfile_2r1w_sb: dual-read, single-write register file with registered reads,
// same-cycle write bypass, byte-masked writes, optional hardwired zero register,
// per-register pending scoreboard and a sequential clear engine.
module regfile_2r1w_sb #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DEPTH      = 2**ADDR_WIDTH,
   parameter int unsigned ZERO_REG   = 1
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    RD_EN,
   input  logic [ADDR_WIDTH-1:0]   ADDR_R1,
   input  logic [ADDR_WIDTH-1:0]   ADDR_R2,
   output logic [DATA_WIDTH-1:0]   DATA_R1,
   output logic [DATA_WIDTH-1:0]   DATA_R2,
   output logic                    BUSY_R1,
   output logic                    BUSY_R2,
   input  logic                    WR_EN,
   input  logic [ADDR_WIDTH-1:0]   ADDR_W,
   input  logic [DATA_WIDTH-1:0]   DATA_W,
   input  logic [DATA_WIDTH/8-1:0] WR_MASK,
   input  logic                    RSV_EN,
   input  logic [ADDR_WIDTH-1:0]   ADDR_RSV,
   input  logic                    CLEAR_REQ,
   output logic                    CLEAR_BUSY
);

   localparam int unsigned BYTES = DATA_WIDTH / 8;
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CMP_W = ADDR_WIDTH + 1;

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } state_t;

   state_t                  state_q;
   state_t                  state_d;
   logic [ADDR_WIDTH-1:0]   cnt_q;
   logic [ADDR_WIDTH-1:0]   cnt_d;
   logic                    clear_busy_q;
   logic                    clear_busy_d;

   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
   logic [DATA_WIDTH-1:0]   mem_d [DEPTH];
   logic [DEPTH-1:0]        pend_q;
   logic [DEPTH-1:0]        pend_d;

   logic [DATA_WIDTH-1:0]   data_r1_q;
   logic [DATA_WIDTH-1:0]   data_r2_q;

   logic                    sweeping;
   logic                    cnt_last;
   logic [IDX_W-1:0]        cnt_idx;
   logic [IDX_W-1:0]        w_idx;
   logic [IDX_W-1:0]        rsv_idx;
   logic [IDX_W-1:0]        r1_idx;
   logic [IDX_W-1:0]        r2_idx;
   logic                    wr_ok;
   logic                    rsv_ok;
   logic                    r1_ok;
   logic                    r2_ok;
   logic [DATA_WIDTH-1:0]   wr_merged;
   logic [DATA_WIDTH-1:0]   rd1_val;
   logic [DATA_WIDTH-1:0]   rd2_val;

   // True when the address names a real, writable/readable register.
   function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
      logic ok;
      ok = ({1'b0, a} < CMP_W'(DEPTH));
      if ((ZERO_REG != 0) && (a == '0)) begin
         ok = 1'b0;
      end
      return ok;
   endfunction

   // Narrow an address to the array index width (only meaningful when addr_ok).
   function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_WIDTH-1:0] a);
      return IDX_W'(a);
   endfunction

   // Byte-masked merge of new data over the old word.
   function automatic logic [DATA_WIDTH-1:0] merge(
      input logic [DATA_WIDTH-1:0] old_w,
      input logic [DATA_WIDTH-1:0] new_w,
      input logic [BYTES-1:0]      mask
   );
      logic [DATA_WIDTH-1:0] r;
      r = old_w;
      for (int k = 0; k < int'(BYTES); k++) begin
         if (mask[k]) begin
            r[8*k +: 8] = new_w[8*k +: 8];
         end
      end
      return r;
   endfunction

   // Request qualification: writes and reservations are suppressed while sweeping.
   always_comb begin
      sweeping  = (state_q == SWEEP);
      cnt_last  = ({1'b0, cnt_q} == CMP_W'(DEPTH - 1));
      cnt_idx   = to_idx(cnt_q);
      w_idx     = to_idx(ADDR_W);
      rsv_idx   = to_idx(ADDR_RSV);
      r1_idx    = to_idx(ADDR_R1);
      r2_idx    = to_idx(ADDR_R2);
      r1_ok     = addr_ok(ADDR_R1);
      r2_ok     = addr_ok(ADDR_R2);
      wr_ok     = WR_EN  && !sweeping && addr_ok(ADDR_W);
      rsv_ok    = RSV_EN && !sweeping && addr_ok(ADDR_RSV);
      wr_merged = merge(mem_q[w_idx], DATA_W, WR_MASK);
   end

   // Clear engine next-state: IDLE waits for a request, SWEEP visits every entry once.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      clear_busy_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (CLEAR_REQ) begin
               state_d = SWEEP;
               cnt_d   = '0;
            end
         end
         SWEEP: begin
            if (cnt_last) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + ADDR_WIDTH'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      clear_busy_d = (state_d == SWEEP);
   end

   // Clear engine state register.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         clear_busy_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         clear_busy_q <= clear_busy_d;
      end
   end

   // Array and scoreboard next values; a reservation beats a write-back on the same entry.
   always_comb begin
      mem_d  = mem_q;
      pend_d = pend_q;
      if (sweeping) begin
         mem_d[cnt_idx]  = '0;
         pend_d[cnt_idx] = 1'b0;
      end else begin
         if (wr_ok) begin
            mem_d[w_idx]  = wr_merged;
            pend_d[w_idx] = 1'b0;
         end
         if (rsv_ok) begin
            pend_d[rsv_idx] = 1'b1;
         end
      end
   end

   // Register array and pending bits.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         pend_q <= '0;
      end else begin
         mem_q  <= mem_d;
         pend_q <= pend_d;
      end
   end

   // Effective read values including the same-cycle write bypass.
   always_comb begin
      rd1_val = '0;
      rd2_val = '0;
      if (r1_ok) begin
         rd1_val = (wr_ok && (ADDR_W == ADDR_R1)) ? wr_merged : mem_q[r1_idx];
      end
      if (r2_ok) begin
         rd2_val = (wr_ok && (ADDR_W == ADDR_R2)) ? wr_merged : mem_q[r2_idx];
      end
   end

   // Registered read ports; hold when RD_EN is low.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         data_r1_q <= '0;
         data_r2_q <= '0;
      end else if (RD_EN) begin
         data_r1_q <= rd1_val;
         data_r2_q <= rd2_val;
      end
   end

   assign DATA_R1    = data_r1_q;
   assign DATA_R2    = data_r2_q;
   assign CLEAR_BUSY = clear_busy_q;
   assign BUSY_R1    = r1_ok && pend_q[r1_idx];
   assign BUSY_R2    = r2_ok && pend_q[r2_idx];

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// tb_regfile_2r1w_sb: directed stimulus with a behavioural reference model and
// a per-cycle comparison of every DUT output.
module tb_regfile_2r1w_sb;

   localparam int DP = 16;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        RD_EN = 1'b0;
   logic [4:0]  ADDR_R1 = '0;
   logic [4:0]  ADDR_R2 = '0;
   logic [31:0] DATA_R1;
   logic [31:0] DATA_R2;
   logic        BUSY_R1;
   logic        BUSY_R2;
   logic        WR_EN = 1'b0;
   logic [4:0]  ADDR_W = '0;
   logic [31:0] DATA_W = '0;
   logic [3:0]  WR_MASK = '0;
   logic        RSV_EN = 1'b0;
   logic [4:0]  ADDR_RSV = '0;
   logic        CLEAR_REQ = 1'b0;
   logic        CLEAR_BUSY;

   int total = 0;
   int bad   = 0;

   regfile_2r1w_sb #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(5),
      .DEPTH(DP),
      .ZERO_REG(1)
   ) dut (
      .CLK(CLK), .RST(RST),
      .RD_EN(RD_EN), .ADDR_R1(ADDR_R1), .ADDR_R2(ADDR_R2),
      .DATA_R1(DATA_R1), .DATA_R2(DATA_R2),
      .BUSY_R1(BUSY_R1), .BUSY_R2(BUSY_R2),
      .WR_EN(WR_EN), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WR_MASK(WR_MASK),
      .RSV_EN(RSV_EN), .ADDR_RSV(ADDR_RSV),
      .CLEAR_REQ(CLEAR_REQ), .CLEAR_BUSY(CLEAR_BUSY)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] m_mem [DP];
   logic        m_pend [DP];
   int          m_left;      // sweep entries still to clear; 0 when idle
   logic [31:0] m_d1, m_d2;
   logic [31:0] v1, v2;
   logic        m_wr;

   function automatic logic usable(input logic [4:0] a);
      return (int'(a) < DP) && (a != 5'd0);
   endfunction

   function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] m);
      logic [31:0] r;
      for (int k = 0; k < 4; k++) r[8*k +: 8] = m[k] ? n[8*k +: 8] : o[8*k +: 8];
      return r;
   endfunction

   function automatic logic [31:0] peek(input logic [4:0] a);
      return usable(a) ? m_mem[a[3:0]] : 32'h0;
   endfunction

   function automatic logic busy_of(input logic [4:0] a);
      return usable(a) ? m_pend[a[3:0]] : 1'b0;
   endfunction

   always @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < DP; i++) begin
            m_mem[i]  = 32'h0;
            m_pend[i] = 1'b0;
         end
         m_left = 0;
         m_d1   = 32'h0;
         m_d2   = 32'h0;
      end else begin
         m_wr = (m_left == 0) && WR_EN && usable(ADDR_W);
         v1 = peek(ADDR_R1);
         v2 = peek(ADDR_R2);
         if (m_wr && ADDR_R1 == ADDR_W) v1 = mrg(v1, DATA_W, WR_MASK);
         if (m_wr && ADDR_R2 == ADDR_W) v2 = mrg(v2, DATA_W, WR_MASK);
         if (RD_EN) begin
            m_d1 = v1;
            m_d2 = v2;
         end
         if (m_left > 0) begin
            m_mem[DP - m_left]  = 32'h0;
            m_pend[DP - m_left] = 1'b0;
            m_left--;
         end else begin
            if (m_wr) begin
               m_mem[ADDR_W[3:0]]  = mrg(m_mem[ADDR_W[3:0]], DATA_W, WR_MASK);
               m_pend[ADDR_W[3:0]] = 1'b0;
            end
            if (RSV_EN && usable(ADDR_RSV)) m_pend[ADDR_RSV[3:0]] = 1'b1;
            if (CLEAR_REQ) m_left = DP;
         end
      end
   end

   // Compare every output against the model, away from the active edge.
   always @(negedge CLK) begin
      chk("cmp_data_r1", DATA_R1, m_d1);
      chk("cmp_data_r2", DATA_R2, m_d2);
      chk("cmp_busy_r1", 32'(BUSY_R1), 32'(busy_of(ADDR_R1)));
      chk("cmp_busy_r2", 32'(BUSY_R2), 32'(busy_of(ADDR_R2)));
      chk("cmp_clear_busy", 32'(CLEAR_BUSY), 32'(m_left > 0));
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m);
      WR_EN = 1'b1; ADDR_W = a; DATA_W = d; WR_MASK = m;
      cyc();
      WR_EN = 1'b0;
   endtask

   task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
      RD_EN = 1'b1; ADDR_R1 = a1; ADDR_R2 = a2;
      cyc();
      RD_EN = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   int n;

   initial begin
      repeat (3) cyc();
      chk("rst_data_r1", DATA_R1, 32'h0);
      chk("rst_clear_busy", 32'(CLEAR_BUSY), 32'h0);
      RST = 1'b1;
      cyc();

      // basic write / registered read, zero register on port 2
      wr(5'd5, 32'hDEADBEEF, 4'hF);
      rd(5'd5, 5'd0);
      chk("rd_r5", DATA_R1, 32'hDEADBEEF);
      chk("rd_r0", DATA_R2, 32'h0);

      // bypass with byte merge on both ports
      wr(5'd7, 32'h11223344, 4'hF);
      RD_EN = 1'b1; ADDR_R1 = 5'd7; ADDR_R2 = 5'd7;
      wr(5'd7, 32'hAABBCCDD, 4'b0101);
      RD_EN = 1'b0;
      chk("bypass_r1", DATA_R1, 32'h11BB33DD);
      chk("bypass_r2", DATA_R2, 32'h11BB33DD);

      // scoreboard
      RSV_EN = 1'b1; ADDR_RSV = 5'd3;
      cyc();
      RSV_EN = 1'b0;
      ADDR_R1 = 5'd3; ADDR_R2 = 5'd4;
      #1;
      chk("rsv_busy", 32'(BUSY_R1), 32'h1);
      RSV_EN = 1'b1; ADDR_RSV = 5'd3;
      wr(5'd3, 32'h0, 4'hF);
      RSV_EN = 1'b0;
      chk("set_wins", 32'(BUSY_R1), 32'h1);
      RSV_EN = 1'b1; ADDR_RSV = 5'd4;
      wr(5'd3, 32'hFFFF_FFFF, 4'h0);
      RSV_EN = 1'b0;
      chk("wr_clears", 32'(BUSY_R1), 32'h0);
      chk("diff_addr_rsv", 32'(BUSY_R2), 32'h1);
      rd(5'd3, 5'd4);
      chk("mask0_nodata", DATA_R1, 32'h0);

      // zero register and out-of-range write
      RSV_EN = 1'b1; ADDR_RSV = 5'd0;
      wr(5'd0, 32'hFFFFFFFF, 4'hF);
      RSV_EN = 1'b0;
      rd(5'd0, 5'd0);
      chk("r0_reads0", DATA_R1, 32'h0);
      chk("r0_notbusy", 32'(BUSY_R1), 32'h0);
      wr(5'd21, 32'h12345678, 4'hF);
      rd(5'd5, 5'd21);
      chk("oor_no_alias", DATA_R1, 32'hDEADBEEF);
      chk("oor_reads0", DATA_R2, 32'h0);

      // fill every register, reserving a varying set alongside
      for (int i = 1; i < DP; i++) begin
         RSV_EN = 1'b1; ADDR_RSV = 5'(DP - i);
         wr(5'(i), 32'(i) * 32'h01010101, 4'hF);
      end
      RSV_EN = 1'b0;

      // sweep; a write, reservation and new request mid-sweep are dropped
      CLEAR_REQ = 1'b1; RD_EN = 1'b1; ADDR_R1 = 5'd15; ADDR_R2 = 5'd10;
      cyc();
      CLEAR_REQ = 1'b0;
      n = 0;
      while (CLEAR_BUSY === 1'b1 && n < 40) begin
         n++;
         if (n == 3) begin
            WR_EN = 1'b1; ADDR_W = 5'd15; DATA_W = 32'h5A5A5A5A; WR_MASK = 4'hF;
            RSV_EN = 1'b1; ADDR_RSV = 5'd10; CLEAR_REQ = 1'b1;
         end
         cyc();
         WR_EN = 1'b0; RSV_EN = 1'b0; CLEAR_REQ = 1'b0;
      end
      RD_EN = 1'b0;
      chk("sweep_len", 32'(n), 32'(DP));
      for (int a = 0; a < DP; a++) begin
         rd(5'(a), 5'(DP - 1 - a));
         chk("post_sweep_data", DATA_R1, 32'h0);
         chk("post_sweep_busy", 32'(BUSY_R1), 32'h0);
      end

      // asynchronous reset in the middle of a sweep
      wr(5'd3, 32'h33333333, 4'hF);
      wr(5'd12, 32'hC0C0C0C0, 4'hF);
      rd(5'd3, 5'd12);
      CLEAR_REQ = 1'b1;
      cyc();
      CLEAR_REQ = 1'b0;
      repeat (3) cyc();
      chk("pre_rst_data", DATA_R1, 32'h33333333);
      chk("pre_rst_busy", 32'(CLEAR_BUSY), 32'h1);
      RST = 1'b0;
      #1;
      chk("async_clear_busy", 32'(CLEAR_BUSY), 32'h0);
      chk("async_data_r1", DATA_R1, 32'h0);
      chk("async_data_r2", DATA_R2, 32'h0);
      repeat (2) cyc();
      RST = 1'b1;
      cyc();
      chk("idle_after_rst", 32'(CLEAR_BUSY), 32'h0);
      for (int a = 0; a < DP; a++) begin
         rd(5'(a), 5'(a));
         chk("post_rst_data", DATA_R2, 32'h0);
      end
      wr(5'd12, 32'hCAFE0000, 4'b1100);
      rd(5'd12, 5'd0);
      chk("idle_accepts_wr", DATA_R1, 32'hCAFE0000);

      cyc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
